// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and default bit timing
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 217;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for one asynchronous bit
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with holding register, framing and overrun flags
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clr,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  logic        rxs;
  uart_state_e state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        ferr_q;
  logic        ovr_q;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d_i  (rxd),
    .q_o  (rxs)
  );

  // Later assignments in the case win: a delivery re-raises valid in a handshake
  // cycle, and a new overrun beats a same-cycle err_clr.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      if (valid_q && rx_ready) valid_q <= 1'b0;
      if (err_clr) ovr_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (!rxs) begin
            bit_q   <= '0;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q   <= '0;
            state_q <= rxs ? ST_IDLE : ST_DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {rxs, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= ST_STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            if (rxs) begin
              state_q <= ST_IDLE;
              if (valid_q && !rx_ready) begin
                ovr_q <= 1'b1;
              end else begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end
            end else begin
              ferr_q  <= 1'b1;
              state_q <= ST_WAIT_HIGH;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_WAIT_HIGH: begin
          if (rxs) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
